// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor with round-to-nearest-even,
// flush-to-zero of denormals and special-value handling.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         underflow,
    output logic         invalid
);

    localparam int MW   = MAN_W + 5;
    localparam int EW   = EXP_W + 1;
    localparam int KMAX = MAN_W + 3;
    localparam int CW   = $clog2(KMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    typedef enum logic [1:0] {K_NUM, K_ZERO, K_INF, K_NAN} kind_t;

    state_t        state_q, state_d;
    kind_t         kind_q, kind_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          op_q, op_d;
    logic          sa_q, sa_d;
    logic          sb_q, sb_d;
    logic          sign_q, sign_d;
    logic [EW-1:0] ea_q, ea_d;
    logic [MW-1:0] ma_q, ma_d;
    logic [MW-1:0] mb_q, mb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  res_q, res_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          inv_q, inv_d;

    logic             s_a, s_b;
    logic [EXP_W-1:0] e_a, e_b;
    logic [MAN_W-1:0] f_a, f_b;
    logic             nan_a, nan_b, inf_a, inf_b;
    logic             swap;
    logic [EXP_W-1:0] e_big, e_sml, diff;
    logic [MW-1:0]    m_a, m_b;

    assign s_a   = a_q[W-1];
    assign s_b   = b_q[W-1] ^ op_q;
    assign e_a   = a_q[W-2:MAN_W];
    assign e_b   = b_q[W-2:MAN_W];
    assign f_a   = a_q[MAN_W-1:0];
    assign f_b   = b_q[MAN_W-1:0];
    assign nan_a = (&e_a) && (|f_a);
    assign nan_b = (&e_b) && (|f_b);
    assign inf_a = (&e_a) && !(|f_a);
    assign inf_b = (&e_b) && !(|f_b);

    // Mantissa layout: {carry, hidden, fraction, guard, round, sticky}
    assign m_a   = (e_a != '0) ? {2'b01, f_a, 3'b000} : '0;
    assign m_b   = (e_b != '0) ? {2'b01, f_b, 3'b000} : '0;
    assign swap  = (e_b > e_a) || ((e_b == e_a) && (f_b > f_a));
    assign e_big = swap ? e_b : e_a;
    assign e_sml = swap ? e_a : e_b;
    assign diff  = e_big - e_sml;

    logic             inc;
    logic             fcarry;
    logic [MAN_W-1:0] frac_r;
    logic [EW-1:0]    e_rnd;

    // Hidden bit is always set here, so a fraction carry means 2.0
    assign inc = ma_q[2] & (ma_q[1] | ma_q[0] | ma_q[3]);
    assign {fcarry, frac_r} = {1'b0, ma_q[MAN_W+2:3]}
                            + {{MAN_W{1'b0}}, inc};
    assign e_rnd = ea_q + {{EXP_W{1'b0}}, fcarry};

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sign_d  = sign_q;
        ea_d    = ea_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        inv_d   = inv_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    inv_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                kind_d = K_NUM;
                if (nan_a || nan_b || (inf_a && inf_b && (s_a != s_b))) begin
                    kind_d  = K_NAN;
                    state_d = S_ROUND;
                end else if (inf_a || inf_b) begin
                    kind_d  = K_INF;
                    sign_d  = inf_a ? s_a : s_b;
                    state_d = S_ROUND;
                end else begin
                    sa_d    = swap ? s_b : s_a;
                    sb_d    = swap ? s_a : s_b;
                    ea_d    = {1'b0, e_big};
                    ma_d    = swap ? m_b : m_a;
                    mb_d    = swap ? m_a : m_b;
                    cnt_d   = (int'(diff) > KMAX) ? CW'(KMAX) : CW'(diff);
                    state_d = (diff != '0) ? S_ALIGN : S_ADD;
                end
            end
            S_ALIGN: begin
                mb_d  = {1'b0, mb_q[MW-1:2], mb_q[1] | mb_q[0]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                ma_d    = (sa_q == sb_q) ? ma_q + mb_q : ma_q - mb_q;
                sign_d  = sa_q;
                state_d = S_NORM;
            end
            S_NORM: begin
                if (ma_q[MW-1]) begin
                    ma_d    = {1'b0, ma_q[MW-1:2], ma_q[1] | ma_q[0]};
                    ea_d    = ea_q + EW'(1);
                    state_d = S_ROUND;
                end else if (ma_q == '0) begin
                    kind_d  = K_ZERO;
                    sign_d  = sa_q & sb_q;
                    state_d = S_ROUND;
                end else if (!ma_q[MW-2]) begin
                    if (ea_q <= EW'(1)) begin
                        kind_d  = K_ZERO;
                        unf_d   = 1'b1;
                        state_d = S_ROUND;
                    end else begin
                        ma_d = {ma_q[MW-2:0], 1'b0};
                        ea_d = ea_q - EW'(1);
                    end
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = S_DONE;
                unique case (kind_q)
                    K_NAN: begin
                        res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                        inv_d = 1'b1;
                    end
                    K_INF: begin
                        res_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end
                    K_ZERO: begin
                        res_d = {sign_q, {(W-1){1'b0}}};
                    end
                    default: begin
                        if (e_rnd >= {1'b0, {EXP_W{1'b1}}}) begin
                            res_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                            ovf_d = 1'b1;
                        end else begin
                            res_d = {sign_q, e_rnd[EXP_W-1:0], frac_r};
                        end
                    end
                endcase
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            kind_q  <= K_NUM;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            sign_q  <= 1'b0;
            ea_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sign_q  <= sign_d;
            ea_q    <= ea_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            inv_q   <= inv_d;
        end
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign result    = res_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign invalid   = inv_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq: directed cases plus randomized single-precision
// operands against an exact-integer rounding model.
module tb_fp_addsub_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        sp_start, sp_op, sp_busy, sp_done, sp_ovf, sp_unf, sp_inv;
    logic [31:0] sp_a, sp_b, sp_res;
    logic        hp_start, hp_op, hp_busy, hp_done, hp_ovf, hp_unf, hp_inv;
    logic [15:0] hp_a, hp_b, hp_res;

    fp_addsub_seq u_sp (
        .clk(clk), .reset(reset), .start(sp_start), .op(sp_op),
        .a(sp_a), .b(sp_b), .busy(sp_busy), .done(sp_done),
        .result(sp_res), .overflow(sp_ovf), .underflow(sp_unf),
        .invalid(sp_inv)
    );

    fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) u_hp (
        .clk(clk), .reset(reset), .start(hp_start), .op(hp_op),
        .a(hp_a), .b(hp_b), .busy(hp_busy), .done(hp_done),
        .result(hp_res), .overflow(hp_ovf), .underflow(hp_unf),
        .invalid(hp_inv)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Exact sum on aligned integer significands, then RNE to 24 bits.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  input logic o, output logic [31:0] r,
                                  output logic [2:0] fl);
        int ex, ey, emin, p, e, sh;
        longint unsigned mx, my, vx, vy, mag, q, rem, half;
        logic sx, sy, s;
        sx = x[31];
        sy = y[31] ^ o;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        mx = (ex != 0) ? longint'({1'b1, x[22:0]}) : 0;
        my = (ey != 0) ? longint'({1'b1, y[22:0]}) : 0;
        fl = 3'b000;
        if (mx == 0 && my == 0) begin
            r = {sx & sy, 31'b0};
            return;
        end
        if (mx == 0) ex = ey;
        if (my == 0) ey = ex;
        emin = (ex < ey) ? ex : ey;
        vx = mx << (ex - emin);
        vy = my << (ey - emin);
        if (sx == sy) begin
            mag = vx + vy; s = sx;
        end else if (vx > vy) begin
            mag = vx - vy; s = sx;
        end else begin
            mag = vy - vx; s = sy;
        end
        if (mag == 0) begin
            r = 32'h0;
            return;
        end
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        e = emin + p - 23;
        if (p > 23) begin
            sh = p - 23;
            q = mag >> sh;
            rem = mag & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e++;
            end
        end else begin
            q = mag << (23 - p);
        end
        if (e <= 0) begin
            r = {s, 31'b0};
            fl = 3'b010;
        end else if (e >= 255) begin
            r = {s, 8'hFF, 23'b0};
            fl = 3'b100;
        end else begin
            r = {s, 8'(e), q[22:0]};
        end
    endfunction

    task automatic run_sp(input logic [31:0] x, input logic [31:0] y,
                          input logic o, input int poke,
                          output logic [31:0] r, output logic [2:0] fl,
                          output int lat);
        logic got;
        @(negedge clk);
        @(negedge clk);
        sp_a = x; sp_b = y; sp_op = o; sp_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sp_start = 1'b0;
        sp_a = $urandom; sp_b = $urandom; sp_op = ~o;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            chk("sp_busy_done_excl", {31'b0, sp_busy & sp_done}, 32'h0);
            if (sp_done) got = 1'b1;
            if (poke > 0 && lat == poke) sp_start = 1'b1;
            else if (poke > 0 && lat == poke + 1) sp_start = 1'b0;
        end
        sp_start = 1'b0;
        chk("sp_done_seen", {31'b0, got}, 32'h1);
        r = sp_res;
        fl = {sp_ovf, sp_unf, sp_inv};
    endtask

    task automatic do_sp(input string tag, input logic [31:0] x,
                         input logic [31:0] y, input logic o,
                         input logic [31:0] er, input logic [2:0] ef,
                         input int elat, input int poke);
        logic [31:0] r;
        logic [2:0] fl;
        int lat;
        run_sp(x, y, o, poke, r, fl, lat);
        chk({tag, "_res"}, r, er);
        chk({tag, "_flags"}, {29'b0, fl}, {29'b0, ef});
        if (elat > 0) chk({tag, "_lat"}, 32'(lat), 32'(elat));
    endtask

    task automatic do_hp(input string tag, input logic [15:0] x,
                         input logic [15:0] y, input logic o,
                         input logic [15:0] er, input logic [2:0] ef,
                         input int elat);
        logic got;
        int lat;
        @(negedge clk);
        @(negedge clk);
        hp_a = x; hp_b = y; hp_op = o; hp_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        hp_start = 1'b0;
        hp_a = 16'($urandom); hp_b = 16'($urandom);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (hp_done) got = 1'b1;
        end
        chk({tag, "_done_seen"}, {31'b0, got}, 32'h1);
        chk({tag, "_res"}, {16'b0, hp_res}, {16'b0, er});
        chk({tag, "_flags"}, {29'b0, hp_ovf, hp_unf, hp_inv}, {29'b0, ef});
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x, y, er, r;
        logic [2:0] ef, fl;
        logic o, seen;
        int ea, eb, d, lat;

        reset = 1'b1;
        sp_start = 1'b0; sp_op = 1'b0; sp_a = '0; sp_b = '0;
        hp_start = 1'b0; hp_op = 1'b0; hp_a = '0; hp_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sp_out", {sp_busy, sp_done, sp_ovf, sp_unf, sp_inv, 27'b0}, 32'h0);
        chk("rst_sp_res", sp_res, 32'h0);
        chk("rst_hp_out", {hp_busy, hp_done, hp_ovf, hp_unf, hp_inv, 27'b0}, 32'h0);
        chk("rst_hp_res", {16'b0, hp_res}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        do_sp("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 4, 0);
        do_sp("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 4, 0);
        do_sp("negzero_sum", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, 4, 0);
        do_sp("tie_even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000, 28, 0);
        do_sp("tie_odd", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000, 28, 0);
        do_sp("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b001, 2, 0);
        do_sp("inf_sub_inf_op", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001, 2, 0);
        do_sp("nan_operand", 32'h3F800000, 32'h7FC00001, 1'b0, 32'h7FC00000, 3'b001, 2, 0);
        do_sp("inf_plus_fin", 32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 3'b000, 2, 0);
        do_sp("start_busy", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000, 28, 3);
        do_sp("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100, 0, 0);

        sp_a = 32'h12345678; sp_b = 32'h9ABCDEF0;
        repeat (5) @(posedge clk);
        #1;
        chk("hold_res", sp_res, 32'h7F800000);
        chk("hold_flags", {29'b0, sp_ovf, sp_unf, sp_inv}, 32'h4);

        @(negedge clk);
        sp_a = 32'h3F800000; sp_b = 32'h33800000; sp_op = 1'b0; sp_start = 1'b1;
        @(posedge clk);
        #1 sp_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_out", {sp_busy, sp_done, sp_ovf, sp_unf, sp_inv, 27'b0}, 32'h0);
        chk("rst_mid_res", sp_res, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (sp_done || sp_busy) seen = 1'b1;
        end
        chk("rst_mid_no_done", {31'b0, seen}, 32'h0);
        do_sp("after_reset", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 4, 0);

        do_hp("hp_one_plus_one", 16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000, 4);
        do_hp("hp_underflow", 16'h0401, 16'h0400, 1'b1, 16'h0000, 3'b010, 4);
        do_hp("hp_inf_minus_inf", 16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 3'b001, 2);

        for (int i = 0; i < 40; i++) begin
            ea = $urandom_range(30, 254);
            if ($urandom_range(0, 7) == 0) ea = 254;
            d = $urandom_range(0, 28);
            eb = ea - d;
            x = {1'($urandom), 8'(ea), 23'($urandom)};
            y = {1'($urandom), 8'(eb), 23'($urandom)};
            if ($urandom_range(0, 3) == 0) y[22:0] = x[22:0] ^ 23'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                r = x; x = y; y = r;
            end
            o = 1'($urandom);
            model(x, y, o, er, ef);
            run_sp(x, y, o, 0, r, fl, lat);
            chk($sformatf("rand%0d_res", i), r, er);
            chk($sformatf("rand%0d_flags", i), {29'b0, fl}, {29'b0, ef});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
